seg7_time_scan: RTL and testbench
=================================

Name: seg7_time_scan

Overview:
- Downstream display stage for the digital clock counter.
- Takes the binary sec/min/hrs time and its set-mode button levels.
- Converts each field to two BCD digits and drives a 6-digit, common-anode, multiplexed 7-segment display on the fast system clock.
- While time is being set, the selected field blinks.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz.
SCAN_HZ, 1000, per-digit scan rate; DIV = CLK_HZ/SCAN_HZ cycles per digit; CLK_HZ divisible by SCAN_HZ; DIV >= 2.
BLINK_HZ, 2, blink rate; HALF = CLK_HZ/(2*BLINK_HZ) cycles per blink phase; HALF >= 2.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
sec  input  6  seconds, binary, legal 0-59
min  input  6  minutes, binary, legal 0-59
hrs  input  5  hours, binary, legal 0-23
set_mode  input  1  time-set mode (button 2 level)
set_min  input  1  minute field being edited (button 3 level)
set_hrs  input  1  hour field being edited (button 4 level)
seg  output  7  segments, active-low; seg[0]=a ... seg[6]=g
an  output  6  digit enables, active-low, one-hot
dp  output  1  decimal point, active-low

Behaviour:
- Reset (reset==0 at a clk edge), all synchronous:
  - an=6'b111111, seg=7'h7F, dp=1
  - scan counter=0, digit index=0
  - blink counter=0, blink phase=0
  - snapshot sec/min/hrs = 0
  - Reset mid-scan aborts immediately: display dark that same edge.
- Scan counter:
  - Counts 0..DIV-1. tick = (count==DIV-1).
  - On tick, index advances 0->1->...->5->0.
- Snapshot:
  - On the tick where index wraps 5->0, sec/min/hrs are captured into the snapshot.
  - Displayed digits come only from the snapshot, so there is no tearing within a frame.
  - Inputs are used asynchronously to clk; they are double-flopped before snapshot capture. This adds 2 cycles of input latency.
- Digit map (index -> an bit low, source):
  - 0: sec units
  - 1: sec tens
  - 2: min units
  - 3: min tens
  - 4: hrs units
  - 5: hrs tens
- BCD conversion:
  - tens = value/10 and units = value%10, by compare-subtract chain. No divider.
  - Out-of-range field (sec or min >= 60, hrs >= 24): both of that field's digits show dash (7'b0111111).
- Segment codes (g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- dp: low on index 2 and 4 (min/hrs separators); high otherwise.
- Registered outputs: seg/an/dp are registered from index and snapshot, giving 1-cycle latency. On the cycle after index changes, the outputs reflect the new digit. No ghosting step.
- Blink:
  - While set_mode==1, the blink counter counts 0..HALF-1 and toggles the phase on wrap.
  - When phase==1: index 2,3 are blanked if set_min==1; index 4,5 are blanked if set_hrs==1.
  - Blanked means the an bit is held high. seg is still driven.
  - Both set_min and set_hrs high: both fields blink together.
- set_mode==0: blink counter and phase are forced to 0 on that edge. Display is fully visible the next cycle.
- Seconds digits never blink.
- No handshake. The block never stalls upstream.

Test Plan (CLK_HZ=60, SCAN_HZ=10 -> DIV=6; BLINK_HZ=1 -> HALF=30):
- Reset: hold reset=0 for 3 cycles -> an=111111, seg=1111111, dp=1. Release -> next cycle an=111110, seg=1000000 (snapshot 0). Each an bit stays low for exactly 6 cycles.
- Snapshot and decode:
  - Apply hrs=23, min=59, sec=7. After the first 5->0 wrap, one frame shows index0..5 = 7,0,9,5,3,2.
  - seg codes: 1111000, 1000000, 0010000, 0010010, 0110000, 0100100.
  - dp=0 only on index 2 and 4.
- Mid-frame input change: change sec from 7 to 8 while index=3 -> digits unchanged until after the next 5->0 wrap, then index0 shows 8 (0000000).
- Out of range: min=60, hrs=24 -> indices 2-5 show 0111111; seconds digits are normal.
- Blink:
  - set_mode=1, set_hrs=1: for 30 cycles all digits are visible, then for 30 cycles an[5:4] stay 11 and an[3:0] scan normally; the pattern repeats.
  - Drop set_mode -> hours digits are visible from the next cycle.
- Reset mid-operation: assert reset while index=4 during blink -> next edge an=111111. After release, scan restarts at index 0 with blink phase 0.

Source files
------------

// File: rtl/seg7_time_scan.sv
// seg7_time_scan
// Display stage for the digital clock. It converts the binary sec/min/hrs
// time into BCD digit pairs and drives a 6-digit, common-anode, multiplexed
// 7-segment display. While the time is being set, the selected field blinks.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   reset     synchronous, active-low reset
//   sec       seconds, binary 0-59 (asynchronous to clk)
//   min       minutes, binary 0-59 (asynchronous to clk)
//   hrs       hours, binary 0-23 (asynchronous to clk)
//   set_mode  time-set mode button level
//   set_min   minute field being edited
//   set_hrs   hour field being edited
//   seg       segments, active-low, seg[0]=a .. seg[6]=g
//   an        digit enables, active-low, one-hot (index 0 = seconds units)
//   dp        decimal point, active-low, lit on the min/hrs separators
module seg7_time_scan #(
  parameter int CLK_HZ   = 50000000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hrs,
  input  logic       set_mode,
  input  logic       set_min,
  input  logic       set_hrs,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp
);

  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W  = $clog2(DIV);
  localparam int BLINK_W = $clog2(HALF);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(HALF - 1);
  localparam logic [6:0]         DASH       = 7'b0111111;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         idx;
  logic               tick;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;

  logic [5:0] sec_meta, sec_sync, sec_snap;
  logic [5:0] min_meta, min_sync, min_snap;
  logic [4:0] hrs_meta, hrs_sync, hrs_snap;

  logic [7:0] sec_bcd, min_bcd, hrs_bcd;
  logic       sec_bad, min_bad, hrs_bad;
  logic [6:0] cur_seg;
  logic       blank;

  assign tick = (scan_cnt == SCAN_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
    end else if (tick) begin
      scan_cnt <= '0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Two-flop synchronisers for the time inputs, which are not related to clk.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sec_meta <= '0;
      sec_sync <= '0;
      min_meta <= '0;
      min_sync <= '0;
      hrs_meta <= '0;
      hrs_sync <= '0;
    end else begin
      sec_meta <= sec;
      sec_sync <= sec_meta;
      min_meta <= min;
      min_sync <= min_meta;
      hrs_meta <= hrs;
      hrs_sync <= hrs_meta;
    end
  end

  // The snapshot only updates at the end of a full frame, so all six digits
  // of one frame always come from the same time value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sec_snap <= '0;
      min_snap <= '0;
      hrs_snap <= '0;
    end else if (tick && idx == 3'd5) begin
      sec_snap <= sec_sync;
      min_snap <= min_sync;
      hrs_snap <= hrs_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || !set_mode) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Compare-subtract chain (40, 20, 10) gives {tens, units} for 0..63
  // without a divider.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    if (r >= 6'd40) begin
      r = r - 6'd40;
      t = t + 4'd4;
    end
    if (r >= 6'd20) begin
      r = r - 6'd20;
      t = t + 4'd2;
    end
    if (r >= 6'd10) begin
      r = r - 6'd10;
      t = t + 4'd1;
    end
    return {t, 4'(r)};
  endfunction

  assign sec_bcd = to_bcd(sec_snap);
  assign min_bcd = to_bcd(min_snap);
  assign hrs_bcd = to_bcd({1'b0, hrs_snap});
  assign sec_bad = (sec_snap >= 6'd60);
  assign min_bad = (min_snap >= 6'd60);
  assign hrs_bad = (hrs_snap >= 5'd24);

  // Blanking is also gated by set_mode itself so that leaving set mode makes
  // the field visible on the very next output update.
  always_comb begin
    cur_seg = 7'b1111111;
    blank   = set_mode && phase &&
              ((set_min && (idx == 3'd2 || idx == 3'd3)) ||
               (set_hrs && (idx == 3'd4 || idx == 3'd5)));
    case (idx)
      3'd0:    cur_seg = sec_bad ? DASH : seg_code(sec_bcd[3:0]);
      3'd1:    cur_seg = sec_bad ? DASH : seg_code(sec_bcd[7:4]);
      3'd2:    cur_seg = min_bad ? DASH : seg_code(min_bcd[3:0]);
      3'd3:    cur_seg = min_bad ? DASH : seg_code(min_bcd[7:4]);
      3'd4:    cur_seg = hrs_bad ? DASH : seg_code(hrs_bcd[3:0]);
      3'd5:    cur_seg = hrs_bad ? DASH : seg_code(hrs_bcd[7:4]);
      default: cur_seg = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seg <= 7'h7F;
      an  <= 6'b111111;
      dp  <= 1'b1;
    end else begin
      seg <= cur_seg;
      an  <= blank ? 6'b111111 : ~(6'b000001 << idx);
      dp  <= !(idx == 3'd2 || idx == 3'd4);
    end
  end

endmodule

// File: tb/tb_seg7_time_scan.sv
// tb_seg7_time_scan
// Directed bench for seg7_time_scan with CLK_HZ=60, SCAN_HZ=10 (6 cycles per
// digit) and BLINK_HZ=1 (30 cycles per blink phase). Expected display values
// are queued against the cycle count since reset release and compared when
// that cycle's output appears.
module tb_seg7_time_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hrs;
  logic       set_mode;
  logic       set_min;
  logic       set_hrs;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;

  localparam logic [6:0] DASH = 7'b0111111;

  int          cyc;
  int          total;
  int          bad;
  int          sbAt[$];
  string       sbTag[$];
  logic [13:0] sbVal[$];

  seg7_time_scan #(
    .CLK_HZ  (60),
    .SCAN_HZ (10),
    .BLINK_HZ(1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sec     (sec),
    .min     (min),
    .hrs     (hrs),
    .set_mode(set_mode),
    .set_min (set_min),
    .set_hrs (set_hrs),
    .seg     (seg),
    .an      (an),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] expSeg(input int idx, input int s, input int m, input int h);
    case (idx)
      0:       return (s >= 60) ? DASH : segOf(s % 10);
      1:       return (s >= 60) ? DASH : segOf(s / 10);
      2:       return (m >= 60) ? DASH : segOf(m % 10);
      3:       return (m >= 60) ? DASH : segOf(m / 10);
      4:       return (h >= 24) ? DASH : segOf(h % 10);
      5:       return (h >= 24) ? DASH : segOf(h / 10);
      default: return DASH;
    endcase
  endfunction

  task automatic applyStimulus(input int s, input int m, input int h,
                               input logic sm, input logic smin, input logic shrs);
    sec      = 6'(s);
    min      = 6'(m);
    hrs      = 5'(h);
    set_mode = sm;
    set_min  = smin;
    set_hrs  = shrs;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] expAn,
                             input logic [6:0] expSegV, input logic expDp);
    total++;
    assert ({an, seg, dp} === {expAn, expSegV, expDp})
    else begin
      bad++;
      $error("[TB] FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
             tag, an, seg, dp, expAn, expSegV, expDp);
    end
  endtask

  task automatic expectDigit(input int at, input string tag, input int idx,
                             input logic [6:0] s, input bit blank);
    logic [5:0] a;
    logic       d;
    a = blank ? 6'b111111 : ~(6'b000001 << idx);
    d = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
    sbAt.push_back(at);
    sbTag.push_back(tag);
    sbVal.push_back({a, s, d});
  endtask

  task automatic tick();
    logic [13:0] v;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sbAt.size() - 1; i >= 0; i--) begin
      if (sbAt[i] == cyc) begin
        v = sbVal[i];
        checkOutput(sbTag[i], v[13:8], v[7:1], v[0]);
        sbAt.delete(i);
        sbTag.delete(i);
        sbVal.delete(i);
      end
    end
  endtask

  task automatic runTo(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("reset_dark", 6'b111111, 7'b1111111, 1'b1);

    $display("[TB] release reset, first frame from zero snapshot");
    reset = 1'b1;
    cyc   = 0;
    expectDigit(1,  "rel_idx0_first", 0, segOf(0), 1'b0);
    expectDigit(6,  "rel_idx0_last",  0, segOf(0), 1'b0);
    expectDigit(7,  "rel_idx1_first", 1, segOf(0), 1'b0);
    expectDigit(13, "rel_idx2_dp",    2, segOf(0), 1'b0);
    runTo(2);

    $display("[TB] decode 23:59:07");
    applyStimulus(7, 59, 23, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      expectDigit(39 + 6 * i, $sformatf("frame1_idx%0d", i), i, expSeg(i, 7, 59, 23), 1'b0);
    runTo(56);

    $display("[TB] mid-frame seconds change");
    applyStimulus(8, 59, 23, 1'b0, 1'b0, 1'b0);
    expectDigit(75, "sec_new_units", 0, segOf(8), 1'b0);
    expectDigit(81, "sec_new_tens",  1, segOf(0), 1'b0);
    runTo(82);

    $display("[TB] out-of-range minutes and hours");
    applyStimulus(8, 60, 24, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      expectDigit(111 + 6 * i, $sformatf("oor_idx%0d", i), i, expSeg(i, 8, 60, 24), 1'b0);
    runTo(110);
    applyStimulus(8, 59, 23, 1'b0, 1'b0, 1'b0);
    runTo(144);

    $display("[TB] blink hours");
    applyStimulus(8, 59, 23, 1'b1, 1'b0, 1'b1);
    expectDigit(170, "blink_idx4_vis",     4, segOf(3), 1'b0);
    expectDigit(174, "blink_idx4_vis_end", 4, segOf(3), 1'b0);
    expectDigit(175, "blink_idx5_blank",   5, segOf(2), 1'b1);
    expectDigit(180, "blink_idx5_blank2",  5, segOf(2), 1'b1);
    expectDigit(200, "blink_min_normal",   3, segOf(5), 1'b0);
    expectDigit(205, "blink_idx4_back",    4, segOf(3), 1'b0);
    expectDigit(242, "blink_idx4_blank",   4, segOf(3), 1'b1);
    runTo(243);
    applyStimulus(8, 59, 23, 1'b0, 1'b0, 1'b1);
    expectDigit(244, "unset_idx4_vis", 4, segOf(3), 1'b0);
    expectDigit(248, "unset_idx5_vis", 5, segOf(2), 1'b0);
    runTo(252);

    $display("[TB] blink again, then reset mid-scan");
    applyStimulus(8, 59, 23, 1'b1, 1'b0, 1'b1);
    expectDigit(290, "sec_never_blinks", 0, segOf(8), 1'b0);
    expectDigit(314, "pre_reset_idx4",   4, segOf(3), 1'b0);
    runTo(314);
    reset = 1'b0;
    tick();
    checkOutput("reset_mid_dark", 6'b111111, 7'b1111111, 1'b1);
    tick();
    checkOutput("reset_mid_hold", 6'b111111, 7'b1111111, 1'b1);

    reset = 1'b1;
    cyc   = 0;
    expectDigit(1,  "rst2_idx0",       0, segOf(0), 1'b0);
    expectDigit(7,  "rst2_idx1",       1, segOf(0), 1'b0);
    expectDigit(26, "rst2_idx4_vis",   4, segOf(0), 1'b0);
    expectDigit(32, "rst2_idx5_blank", 5, segOf(0), 1'b1);
    runTo(36);

    total++;
    assert (sbAt.size() == 0)
    else begin
      bad++;
      $error("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sbAt.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
